soc_dpram_mw: RTL
=================

# soc_dpram_mw

Parametrised mixed-width true dual-port on-chip RAM with two Avalon-MM slaves: a narrow port (s1) and a wide port (s2, RATIO × narrow), both byte-enabled. It adds a selectable read latency with `readdatavalid`, deterministic resolution of same-cycle write collisions, and an optional zero-fill engine that runs after reset. It sits on the SoC fabric as shared memory between the CPU data master (s2) and a 16-bit peripheral/DMA master (s1).

## Interface
- `DATA_WIDTH_A`, 16: narrow port width; must be a multiple of `BYTE_SIZE`.
- `RATIO`, 2: wide/narrow width ratio; legal values 1, 2, 4.
- `DEPTH_B`, 1024: wide-port words; power of two.
- `BYTE_SIZE`, 8: bits per byte-enable lane.
- `READ_LATENCY`, 1: 1 = unregistered RAM output, 2 = extra output register.
- `CLEAR_ON_RESET`, 0: 1 = zero-fill the whole array after reset.
- `INIT_FILE`, "soc_dpram_mw.hex": initial contents, used when `CLEAR_ON_RESET` = 0.
- Derived widths:
  - `DATA_WIDTH_B` = `DATA_WIDTH_A`·`RATIO`
  - `DEPTH_A` = `DEPTH_B`·`RATIO`
  - `AW_A` / `AW_B` = clog2 of the respective depths
  - `BE_A` / `BE_B` = width/`BYTE_SIZE`
- Ports:
  - `clk` in 1: single clock for both ports.
  - `reset` in 1: asynchronous, active-high.
  - `reset_req` in 1: global clock-enable kill; freezes all state while high.
  - `address`, `byteenable`, `chipselect`, `write`, `writedata`, `clken` in `AW_A`/`BE_A`/1/1/`DATA_WIDTH_A`/1: s1 command.
  - `readdata` out `DATA_WIDTH_A`, `readdatavalid` out 1, `waitrequest` out 1: s1 response.
  - `address2`, `byteenable2`, `chipselect2`, `write2`, `writedata2`, `clken2` in `AW_B`/`BE_B`/1/1/`DATA_WIDTH_B`/1: s2 command.
  - `readdata2` out `DATA_WIDTH_B`, `readdatavalid2` out 1, `waitrequest2` out 1: s2 response.
  - `clear_busy` out 1: zero-fill in progress.

## Operation
- Storage: `DEPTH_B` wide words, organised as `BE_B` independent byte lanes.
- s1 address mapping: word = `address` >> log2(`RATIO`); lane = `address`[log2(`RATIO`)-1:0]. Lane 0 occupies the LSBs (little-endian).
- A command is accepted when `chipselect` & `clken` & ~`waitrequest` & ~`reset_req`.
- Accepted write: bytes with an asserted enable are written; `readdatavalid` is not raised.
- Accepted read: returns the full port-width word; byte enables are ignored.
- Write collision (both ports write the same wide word in the same cycle):
  - overlapping bytes take s2 data;
  - non-overlapping bytes from both ports are all written.
- Mixed-port read-during-write: the reading port returns OLD data.
- FSM states, in the shared package:
  - `RESET`: held while `reset` is high.
  - `CLEAR`: writes zero to one wide word per cycle, counter 0..`DEPTH_B`-1. `waitrequest`, `waitrequest2` and `clear_busy` are high.
  - `READY`: normal operation.
- Transitions:
  - `RESET` → `CLEAR` if `CLEAR_ON_RESET`, else → `READY`.
  - `CLEAR` → `READY` after the word `DEPTH_B`-1 has been written.
- Reset asserted mid-clear aborts the fill; the fill restarts from word 0 after release.
- `reset_req` high:
  - freezes the FSM, the clear counter and the read pipelines;
  - forces `readdatavalid`/`readdatavalid2` low;
  - blocks new commands.
- Reads pending when `reset_req` rises keep their data and complete after `reset_req` falls, with cycles shifted by the freeze length.
- Memory contents are never changed by `reset` except through `CLEAR`.

## Timing
- Values while `reset` is high:
  - `readdata`, `readdata2`: 0.
  - `readdatavalid`, `readdatavalid2`: 0.
  - `waitrequest`, `waitrequest2`, `clear_busy`: `CLEAR_ON_RESET`.
- Read latency is `READY`-state cycles from acceptance to the `readdatavalid` pulse:
  - `READ_LATENCY` = 1: data valid in the cycle after acceptance;
  - `READ_LATENCY` = 2: data valid two cycles after acceptance.
- Each port's pipeline is fully pipelined: one read accepted per cycle per port, with no bubbles.
- `clken` low only blocks acceptance; in-flight reads still complete.
- Between pulses, `readdata` holds the last returned value.
- Write-to-read on the same port: a read accepted in the cycle after a write returns the new data.
- `CLEAR` duration is exactly `DEPTH_B` cycles. `waitrequest` falls in the first `READY` cycle.

## Structure
- Package `soc_dpram_pkg` contains:
  - the FSM state enum;
  - a clog2 function;
  - the lane-index and word-index helper functions;
  - legal-`RATIO` and `READ_LATENCY` range constants, checked with elaboration-time assertions.
- Sub-module `soc_dpram_rdpipe`: one instance per port. It carries the valid bit and data delay line for `READ_LATENCY`, with the `reset_req` freeze and the valid gating.
- The top level contains:
  - the byte-lane arrays;
  - collision merge;
  - the clear FSM;
  - the acceptance logic.

## Test plan
- Lane mapping (defaults): s1 writes 0x1234 to addr 3, then s2 reads addr 1 → 0x1234_xxxx, with the upper half = 0x1234. s2 writes 0xAABBCCDD to addr 5; s1 reads addr 10/11 → 0xCCDD/0xAABB.
- Collision: same cycle, s1 writes 0x1111 with be=11 to addr 0, and s2 writes 0x22223333 with be=0011 to addr 0. Reading word 0 → 0x????3333 for the s2-enabled bytes; repeat with s1 addr 1 → 0x11113333.
- Latency: for `READ_LATENCY` = 1 and 2, issue back-to-back reads on both ports with `clken` toggling. `readdatavalid` pulses exactly 1/2 cycles after each acceptance, with no lost or duplicated pulses.
- Mixed read-during-write: s2 reads word 7 (old 0x0) while s1 writes it → 0x0 returned; a later read returns the new value.
- Clear: with `CLEAR_ON_RESET` = 1 and `DEPTH_B` = 16, `waitrequest` stays high 16 cycles after release. Re-assert `reset` at clear cycle 5 → the fill restarts, and all words read 0.
- Freeze: assert `reset_req` for 3 cycles with one read in flight. No valid pulse appears during the freeze; the data arrives correctly after release, delayed 3 cycles.

Source files
------------

// File: rtl/soc_dpram_pkg.sv
// soc_dpram_pkg: shared types, limits and address helpers for the mixed-width dual-port RAM
package soc_dpram_pkg;
   typedef enum logic [1:0] {RESET, CLEAR, READY} state_t;
   localparam int RATIO_MIN = 1;
   localparam int RATIO_MAX = 4;
   localparam int RL_MIN = 1;
   localparam int RL_MAX = 2;
   function automatic int clog2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic int lane_of(input int addr, input int ratio);
      return addr % ratio;
   endfunction
   function automatic int word_of(input int addr, input int ratio);
      return addr / ratio;
   endfunction
endpackage

// File: rtl/soc_dpram_rdpipe.sv
// soc_dpram_rdpipe: read valid/data delay line of LAT stages with freeze and valid gating
// Ports: clk, reset (async, active-high), freeze (holds every stage and masks valid),
//        in_valid/in_data (accepted read and raw RAM word), valid/data (port response).
module soc_dpram_rdpipe
   import soc_dpram_pkg::*;
#(
   parameter int W = 16,
   parameter int LAT = 1
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         freeze,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         valid,
   output logic [W-1:0] data
);
   if (LAT < RL_MIN || LAT > RL_MAX) begin : g_bad_lat
      $error("soc_dpram_rdpipe: LAT out of range");
   end
   logic [LAT-1:0] v;
   logic [W-1:0] d [LAT];
   // data stages only load behind a valid bit, so the output holds the last returned word
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         v <= '0;
         for (int i = 0; i < LAT; i++) d[i] <= '0;
      end else if (!freeze) begin
         v[0] <= in_valid;
         if (in_valid) d[0] <= in_data;
         for (int i = 1; i < LAT; i++) begin
            v[i] <= v[i-1];
            if (v[i-1]) d[i] <= d[i-1];
         end
      end
   assign valid = v[LAT-1] & ~freeze;
   assign data = d[LAT-1];
endmodule

// File: rtl/soc_dpram_mw.sv
// soc_dpram_mw: mixed-width true dual-port byte-enabled RAM with two Avalon-MM slaves
// Ports: clk, reset (async, active-high), reset_req (freezes all state, blocks commands),
//        s1 narrow slave: address/byteenable/chipselect/write/writedata/clken -> readdata/readdatavalid/waitrequest,
//        s2 wide slave:   address2/byteenable2/chipselect2/write2/writedata2/clken2 -> readdata2/readdatavalid2/waitrequest2,
//        clear_busy (post-reset zero-fill running).
module soc_dpram_mw
   import soc_dpram_pkg::*;
#(
   parameter int    DATA_WIDTH_A = 16,
   parameter int    RATIO = 2,
   parameter int    DEPTH_B = 1024,
   parameter int    BYTE_SIZE = 8,
   parameter int    READ_LATENCY = 1,
   parameter bit    CLEAR_ON_RESET = 0,
   parameter string INIT_FILE = "soc_dpram_mw.hex",
   localparam int   DATA_WIDTH_B = DATA_WIDTH_A * RATIO,
   localparam int   DEPTH_A = DEPTH_B * RATIO,
   localparam int   AW_A = clog2(DEPTH_A),
   localparam int   AW_B = clog2(DEPTH_B),
   localparam int   BE_A = DATA_WIDTH_A / BYTE_SIZE,
   localparam int   BE_B = DATA_WIDTH_B / BYTE_SIZE
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    reset_req,
   input  logic [AW_A-1:0]         address,
   input  logic [BE_A-1:0]         byteenable,
   input  logic                    chipselect,
   input  logic                    write,
   input  logic [DATA_WIDTH_A-1:0] writedata,
   input  logic                    clken,
   output logic [DATA_WIDTH_A-1:0] readdata,
   output logic                    readdatavalid,
   output logic                    waitrequest,
   input  logic [AW_B-1:0]         address2,
   input  logic [BE_B-1:0]         byteenable2,
   input  logic                    chipselect2,
   input  logic                    write2,
   input  logic [DATA_WIDTH_B-1:0] writedata2,
   input  logic                    clken2,
   output logic [DATA_WIDTH_B-1:0] readdata2,
   output logic                    readdatavalid2,
   output logic                    waitrequest2,
   output logic                    clear_busy
);
   if (RATIO < RATIO_MIN || RATIO > RATIO_MAX || RATIO == 3) begin : g_bad_ratio
      $error("soc_dpram_mw: RATIO must be 1, 2 or 4");
   end
   if (DATA_WIDTH_A % BYTE_SIZE != 0) begin : g_bad_width
      $error("soc_dpram_mw: DATA_WIDTH_A must be a multiple of BYTE_SIZE");
   end
   // the preload image is attached by the implementation flow; it must be named when no fill runs
   if (!CLEAR_ON_RESET && INIT_FILE == "") begin : g_no_init
      $error("soc_dpram_mw: INIT_FILE required when CLEAR_ON_RESET is 0");
   end
   state_t state, state_n;
   logic [AW_B-1:0] cnt, cnt_n, s1_word;
   int s1_lane;
   logic busy, acc1, acc2, clr_we;
   logic [DATA_WIDTH_B-1:0] rd_wide1, rd_wide2;
   logic [DATA_WIDTH_A-1:0] rd1;
   assign busy = state == CLEAR || (state == RESET && CLEAR_ON_RESET);
   assign waitrequest = busy;
   assign waitrequest2 = busy;
   assign clear_busy = busy;
   assign acc1 = chipselect && clken && !busy && !reset_req;
   assign acc2 = chipselect2 && clken2 && !busy && !reset_req;
   assign clr_we = state == CLEAR && !reset_req;
   assign s1_word = AW_B'(word_of(int'(address), RATIO));
   assign s1_lane = lane_of(int'(address), RATIO);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= RESET;
         cnt <= '0;
      end else if (!reset_req) begin
         state <= state_n;
         cnt <= cnt_n;
      end
   always_comb begin
      state_n = state == RESET ? (CLEAR_ON_RESET ? CLEAR : READY) :
                (state == CLEAR && cnt == AW_B'(DEPTH_B - 1)) ? READY : state;
      cnt_n = state == CLEAR ? cnt + 1'b1 : '0;
   end
   // each byte lane is a two-write-port array; the clear engine borrows the s2 port, and
   // s2 is written last so it wins any byte that both ports hit in the same word
   for (genvar l = 0; l < BE_B; l++) begin : g_lane
      logic [BYTE_SIZE-1:0] mem [DEPTH_B];
      logic we1, we2;
      logic [AW_B-1:0] wa2;
      logic [BYTE_SIZE-1:0] wd2;
      assign we1 = acc1 && write && s1_lane == l / BE_A && byteenable[l % BE_A];
      assign we2 = clr_we || (acc2 && write2 && byteenable2[l]);
      assign wa2 = clr_we ? cnt : address2;
      assign wd2 = clr_we ? '0 : writedata2[l*BYTE_SIZE +: BYTE_SIZE];
      always_ff @(posedge clk) begin
         if (we1) mem[s1_word] <= writedata[(l % BE_A)*BYTE_SIZE +: BYTE_SIZE];
         if (we2) mem[wa2] <= wd2;
      end
      assign rd_wide1[l*BYTE_SIZE +: BYTE_SIZE] = mem[s1_word];
      assign rd_wide2[l*BYTE_SIZE +: BYTE_SIZE] = mem[address2];
   end
   assign rd1 = rd_wide1[s1_lane*DATA_WIDTH_A +: DATA_WIDTH_A];
   soc_dpram_rdpipe #(.W(DATA_WIDTH_A), .LAT(READ_LATENCY)) u_rd1 (
      .clk(clk), .reset(reset), .freeze(reset_req), .in_valid(acc1 && !write),
      .in_data(rd1), .valid(readdatavalid), .data(readdata)
   );
   soc_dpram_rdpipe #(.W(DATA_WIDTH_B), .LAT(READ_LATENCY)) u_rd2 (
      .clk(clk), .reset(reset), .freeze(reset_req), .in_valid(acc2 && !write2),
      .in_data(rd_wide2), .valid(readdatavalid2), .data(readdata2)
   );
endmodule
